spi_flash_slave: RTL and testbench

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

---
 rtl/spi_flash_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_spi_flash_slave.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_slave.sv
// spi_flash_slave
// Read-only SPI (mode 0, MSB first) front end for a word-organised memory.
// The master sends the opcode CMD_READ, then a 24-bit byte address, then
// clocks out data for as long as ss_n stays low. Each 32-bit word is fetched
// once with a one-cycle rd_en strobe; the remaining byte lanes of that word
// are served from a held copy. Any other opcode raises cmd_err for one cycle
// and the rest of the transfer is ignored.
//
// Ports
//   clock, reset     system clock, asynchronous active-high reset
//   sck, ss_n, mosi  SPI bus from the master (asynchronous to clock)
//   miso             serial read data to the master
//   rd_en, rd_addr   one-cycle word read strobe and word address (A[23:2])
//   rd_data          memory word, valid the cycle after rd_en
//   cmd_err          one-cycle pulse on an unsupported opcode
module spi_flash_slave #(
  parameter logic [7:0] CMD_READ    = 8'h03,
  parameter int         SYNC_STAGES = 2   // must be at least 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        mosi,
  output logic        miso,
  output logic        rd_en,
  output logic [21:0] rd_addr,
  input  logic [31:0] rd_data,
  output logic        cmd_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    FETCH  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise_s, sck_fall_s, ss_rise_s, ss_fall_s;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] addr_q, addr_d;     // also collects the opcode during CMD
  logic [7:0]  tx_q, tx_d;
  logic [31:0] word_q, word_d;
  logic        miso_q, miso_d;
  logic        rd_en_q, rd_en_d;
  logic [21:0] rd_addr_q, rd_addr_d;
  logic        cmd_err_q, cmd_err_d;
  logic [23:0] addr_shift_s, addr_next_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // mosi goes through the same number of stages as sck, so it is still
  // aligned with the detected rising edge
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign ss_rise_s  = ss_s & ~ss_prev_q;
  assign ss_fall_s  = ~ss_s & ss_prev_q;

  assign addr_shift_s = {addr_q[22:0], mosi_s};
  assign addr_next_s  = addr_q + 24'd1;   // wraps FFFFFF -> 000000

  assign miso    = miso_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign cmd_err = cmd_err_q;

  // Input synchronizers and edge-detect history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q  <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 6'd0;
      addr_q    <= 24'd0;
      tx_q      <= 8'd0;
      word_q    <= 32'd0;
      miso_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 22'd0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      word_q    <= word_d;
      miso_q    <= miso_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    word_d    = word_q;
    miso_d    = miso_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    cmd_err_d = 1'b0;

    if (ss_rise_s) begin
      // deselect wins over any coincident sck edge and drops a pending fetch
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = 6'd0;
      tx_d      = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall_s) begin
            state_d   = CMD;
            bit_cnt_d = 6'd0;
          end else begin
            state_d = IDLE;
          end
        end
        CMD: begin
          if (sck_rise_s) begin
            addr_d = addr_shift_s;
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = 6'd0;
              if (addr_shift_s[7:0] == CMD_READ) begin
                state_d = ADDR;
              end else begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end else begin
            state_d = CMD;
          end
        end
        ADDR: begin
          if (sck_rise_s) begin
            addr_d = addr_shift_s;
            if (bit_cnt_q == 6'd23) begin
              bit_cnt_d = 6'd0;
              state_d   = FETCH;
              rd_en_d   = 1'b1;
              rd_addr_d = addr_shift_s[23:2];
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end else begin
            state_d = ADDR;
          end
        end
        FETCH: begin
          miso_d = 1'b0;
          // first FETCH cycle carries the strobe; the word arrives the next one
          if (rd_en_q) begin
            state_d = FETCH;
          end else begin
            word_d  = rd_data;
            tx_d    = rd_data[{addr_q[1:0], 3'b000} +: 8];
            state_d = DATA;
          end
        end
        DATA: begin
          if (sck_rise_s) begin
            if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = 6'd0;
              addr_d    = addr_next_s;
              if (addr_next_s[1:0] == 2'd0) begin
                state_d   = FETCH;
                rd_en_d   = 1'b1;
                rd_addr_d = addr_next_s[23:2];
                miso_d    = 1'b0;
              end else begin
                tx_d = word_q[{addr_next_s[1:0], 3'b000} +: 8];
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end else if (sck_fall_s) begin
            // the first fall of a byte presents tx[7]; later falls shift
            if (bit_cnt_q == 6'd0) begin
              miso_d = tx_q[7];
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              miso_d = tx_q[6];
            end
          end else begin
            state_d = DATA;
          end
        end
        IGNORE: begin
          miso_d  = 1'b0;
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_slave.sv
module tb_spi_flash_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck   = 1'b0;
  logic        ss_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic        rd_en;
  logic [21:0] rd_addr;
  logic [31:0] rd_data = 32'h0;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_flash_slave #(.CMD_READ(8'h03), .SYNC_STAGES(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .sck    (sck),
    .ss_n   (ss_n),
    .mosi   (mosi),
    .miso   (miso),
    .rd_en  (rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .cmd_err(cmd_err)
  );

  // Backing memory: words not written by a test get random content on first use
  logic [31:0] mem [logic [21:0]];

  function automatic logic [31:0] get_word(input logic [21:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Memory responds exactly one clock after rd_en, zero otherwise
  always @(posedge clock) begin
    if (rd_en === 1'b1) rd_data <= get_word(rd_addr);
    else rd_data <= 32'h0;
  end

  // Bus monitor, sampled on the inactive clock edge
  logic [21:0] rd_log[$];
  int cmd_err_cnt = 0;
  int miso_hi_cnt = 0;
  always @(negedge clock) begin
    if (rd_en === 1'b1) rd_log.push_back(rd_addr);
    if (cmd_err === 1'b1) cmd_err_cnt++;
    if (miso === 1'b1) miso_hi_cnt++;
  end

  // Reference model: byte stream and expected word fetches of a read
  logic [7:0]  exp_bytes[$];
  logic [21:0] exp_rds[$];

  task automatic build_model(input logic [23:0] a, input int n);
    logic [23:0] b;
    logic [31:0] w;
    exp_bytes.delete();
    exp_rds.delete();
    exp_rds.push_back(a[23:2]);
    for (int i = 0; i < n; i++) begin
      b = a + i[23:0];
      w = get_word(b[23:2]) >> (8 * b[1:0]);
      exp_bytes.push_back(w[7:0]);
      if (i > 0 && b[1:0] == 2'd0) exp_rds.push_back(b[23:2]);
    end
  endtask

  // SPI master, sck = clock/8
  logic [7:0] rx_q[$];

  task automatic spi_bit(input logic b, input logic last, output logic r);
    mosi = b;
    repeat (4) @(negedge clock);
    r   = miso;
    sck = 1'b1;
    if (last) ss_n = 1'b1;
    repeat (4) @(negedge clock);
    sck = 1'b0;
  endtask

  task automatic read_xfer(input logic [7:0] op, input logic [23:0] a, input int n);
    logic [31:0] hdr;
    logic [7:0]  r;
    logic        rb;
    hdr = {op, a};
    rx_q.delete();
    ss_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 31; i >= 0; i--) spi_bit(hdr[i], 1'b0, rb);
    for (int k = 0; k < n; k++) begin
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        spi_bit(1'b0, (k == n - 1) && (i == 0), rb);
        r[i] = rb;
      end
      rx_q.push_back(r);
    end
    ss_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    checks++; if (rd_addr !== 22'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", rd_addr); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_basic_read();
    logic [7:0]  eb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int s;
    mem[22'h0] = 32'h44332211;
    s = rd_log.size();
    read_xfer(8'h03, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== eb[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, rx_q[i], eb[i]); end
    end
    checks++;
    if (rd_log.size() - s != 1) begin errors++; $display("FAIL basic_rd_count: got %0d expected 1", rd_log.size() - s); end
    else begin
      checks++;
      if (rd_log[s] !== 22'h0) begin errors++; $display("FAIL basic_rd_addr: got %h expected 0", rd_log[s]); end
    end
  endtask

  task automatic test_unaligned();
    logic [7:0]  eb[4] = '{8'hCC, 8'hDD, 8'h55, 8'h66};
    logic [21:0] ea[2] = '{22'h1, 22'h2};
    int s;
    mem[22'h1] = 32'hDDCCBBAA;
    mem[22'h2] = 32'h88776655;
    s = rd_log.size();
    read_xfer(8'h03, 24'h000006, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== eb[i]) begin errors++; $display("FAIL unaligned_byte%0d: got %h expected %h", i, rx_q[i], eb[i]); end
    end
    checks++;
    if (rd_log.size() - s != 2) begin errors++; $display("FAIL unaligned_rd_count: got %0d expected 2", rd_log.size() - s); end
    else for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_log[s+i] !== ea[i]) begin errors++; $display("FAIL unaligned_rd_addr%0d: got %h expected %h", i, rd_log[s+i], ea[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  eb[2] = '{8'hA1, 8'h11};
    logic [21:0] ea[2] = '{22'h3FFFFF, 22'h0};
    int s;
    mem[22'h3FFFFF] = 32'hA1B2C3D4;
    mem[22'h0]      = 32'h44332211;
    s = rd_log.size();
    read_xfer(8'h03, 24'hFFFFFF, 2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_q[i] !== eb[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, rx_q[i], eb[i]); end
    end
    checks++;
    if (rd_log.size() - s != 2) begin errors++; $display("FAIL wrap_rd_count: got %0d expected 2", rd_log.size() - s); end
    else for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_log[s+i] !== ea[i]) begin errors++; $display("FAIL wrap_rd_addr%0d: got %h expected %h", i, rd_log[s+i], ea[i]); end
    end
  endtask

  task automatic test_bad_opcode();
    int s, c, m;
    s = rd_log.size();
    c = cmd_err_cnt;
    m = miso_hi_cnt;
    read_xfer(8'h0B, 24'($urandom), 0);
    checks++; if (cmd_err_cnt - c != 1) begin errors++; $display("FAIL badop_cmd_err: got %0d pulses expected 1", cmd_err_cnt - c); end
    checks++; if (miso_hi_cnt - m != 0) begin errors++; $display("FAIL badop_miso: got %0d high cycles expected 0", miso_hi_cnt - m); end
    checks++; if (rd_log.size() - s != 0) begin errors++; $display("FAIL badop_rd_en: got %0d reads expected 0", rd_log.size() - s); end
  endtask

  task automatic test_abort();
    logic [7:0] eb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [19:0] bits;
    logic rb;
    int s;
    mem[22'h0] = 32'h44332211;
    bits = {8'h03, 12'hFFF};
    s = rd_log.size();
    ss_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 19; i >= 0; i--) spi_bit(bits[i], 1'b0, rb);
    ss_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++; if (rd_log.size() - s != 0) begin errors++; $display("FAIL abort_rd_en: got %0d reads expected 0", rd_log.size() - s); end
    read_xfer(8'h03, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== eb[i]) begin errors++; $display("FAIL abort_byte%0d: got %h expected %h", i, rx_q[i], eb[i]); end
    end
    checks++;
    if (rd_log.size() - s != 1 || rd_log[rd_log.size()-1] !== 22'h0) begin
      errors++; $display("FAIL abort_rd: got %0d reads expected 1 at addr 0", rd_log.size() - s);
    end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] eb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [31:0] hdr;
    logic rb;
    int s, m;
    mem[22'h0] = 32'h44332211;
    hdr = {8'h03, 24'h000000};
    ss_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 31; i >= 0; i--) spi_bit(hdr[i], 1'b0, rb);
    for (int i = 0; i < 10; i++) spi_bit(1'b0, 1'b0, rb);
    repeat (4) @(negedge clock);
    // byte 2 is 0x22; its third bit (a one) is now on miso
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rstmid_pre_miso: got %b expected 1", miso); end
    s = rd_log.size();
    reset = 1'b1;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b expected 0", miso); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b expected 0", rd_en); end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    m = miso_hi_cnt;
    // bits still clocked under the old select must be ignored
    for (int i = 0; i < 8; i++) spi_bit(1'($urandom), 1'b0, rb);
    ss_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++; if (miso_hi_cnt - m != 0) begin errors++; $display("FAIL rstmid_post_miso: got %0d high cycles expected 0", miso_hi_cnt - m); end
    checks++; if (rd_log.size() - s != 0) begin errors++; $display("FAIL rstmid_rd_en_after: got %0d reads expected 0", rd_log.size() - s); end
    read_xfer(8'h03, 24'h000000, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[i] !== eb[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, rx_q[i], eb[i]); end
    end
  endtask

  task automatic test_random_reads();
    logic [23:0] a;
    int n, s;
    for (int it = 0; it < 8; it++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 9);
      build_model(a, n);
      s = rd_log.size();
      read_xfer(8'h03, a, n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_q[i] !== exp_bytes[i]) begin
          errors++; $display("FAIL rand%0d_byte%0d: addr %h got %h expected %h", it, i, a, rx_q[i], exp_bytes[i]);
        end
      end
      checks++;
      if (rd_log.size() - s != exp_rds.size()) begin
        errors++; $display("FAIL rand%0d_rd_count: addr %h got %0d expected %0d", it, a, rd_log.size() - s, exp_rds.size());
      end else begin
        for (int i = 0; i < exp_rds.size(); i++) begin
          checks++;
          if (rd_log[s+i] !== exp_rds[i]) begin
            errors++; $display("FAIL rand%0d_rd_addr%0d: got %h expected %h", it, i, rd_log[s+i], exp_rds[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_unaligned();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_reset_mid_data();
    test_random_reads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
